// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID->EX pipeline register with valid/ready handshake, flush
// and an optional 2-entry skid buffer. When SKID=1, in_ready is registered, so
// there is no combinational path from out_ready to in_ready. All state changes
// happen on the falling edge of clk. stall_cnt counts back-pressure edges and
// saturates.
module id_ex_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dato_a,
  input  logic [DATA_W-1:0] dato_b,
  input  logic [REG_W-1:0]  shamt,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dato_a_out,
  output logic [DATA_W-1:0] dato_b_out,
  output logic [REG_W-1:0]  shamt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  // A bundle is packed as {dato_a, dato_b, shamt, rd, rt}.
  localparam int BW = 2 * DATA_W + 3 * REG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    main_q, main_d;
  logic [BW-1:0]    skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [BW-1:0]    in_bundle;
  logic             in_fire;
  logic             out_fire;

  assign in_bundle = {dato_a, dato_b, shamt, rd, rt};
  assign out_valid = (state_q != EMPTY);
  // With SKID=1, in_ready comes from a register. With SKID=0, the stage can
  // accept new data whenever it is empty or is being drained in this cycle.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The data outputs come only from the main register, so no input reaches
  // them combinationally.
  assign {dato_a_out, dato_b_out, shamt_out, rd_out, rt_out} = main_q;
  assign stall_cnt = stall_q;

  // Next-state logic: fill and drain the main and skid entries. Flush takes
  // priority over normal flow.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          main_d  = in_bundle;
        end
      end
      FULL: begin
        if (SKID != 0) begin
          if (in_fire && !out_fire) begin
            state_d = SKIDF;
            skid_d  = in_bundle;
          end else if (in_fire && out_fire) begin
            main_d = in_bundle;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end else begin
          if (in_fire) begin
            main_d = in_bundle;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
      end
      SKIDF: begin
        if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush drops the stored bundle and any bundle offered on the same edge.
    // The data outputs keep their last values.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    in_ready_d = (state_d != SKIDF);
  end

  // State register. Updates on the falling edge, with synchronous reset.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

endmodule
